// File: rtl/llfifo_pkg.sv
// Shared definitions for the linked-list multi-FIFO pop path: index-width
// helper, count-bus field slicing and skid-buffer occupancy encoding.
package llfifo_pkg;

   // Number of bits needed to represent v (at least one).
   function automatic int log2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((v >> i) != 0) r = i + 1;
      end
      return r;
   endfunction

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } skid_occ_e;

endpackage

`define LLFIFO_CNT_FIELD(bus, i, w) bus[((i)+1)*(w)-1 -: (w)]

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: grants the first requester at or after ptr, modulo N.
module rr_arbiter
   import llfifo_pkg::*;
#(
   parameter int N = 8,
   parameter int W = log2(N - 1)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         gnt_valid,
   output logic [W-1:0] gnt_idx
);

   logic [W:0]   sum;
   logic [W-1:0] idx;

   // Scan N candidates starting at ptr; the first hit wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (W+1)'(k);
         if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
         end else begin
            sum = sum;
         end
         idx = sum[W-1:0];
         if (!gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx;
         end else begin
            gnt_valid = gnt_valid;
         end
      end
   end

endmodule

// File: rtl/llfifo_pop_scheduler.sv
// Round-robin pop scheduler between the linked-list multi-FIFO buffer and one consumer.
// Optional weighted mode (QUANTUM-long bursts) is enabled by defining LLFIFO_SCHED_WRR_EN.
module llfifo_pop_scheduler
   import llfifo_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 32,
   parameter int FIFOS      = 8,
   parameter int LOG2_FIFOS = log2(FIFOS - 1),
   parameter int LOG2_DEPTH = log2(DEPTH - 1),
   parameter int QUANTUM    = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [FIFOS-1:0]             en_mask,
   input  logic [LOG2_DEPTH*FIFOS-1:0]  count,
   output logic                         pop,
   output logic [LOG2_FIFOS-1:0]        pop_fifo,
   input  logic [WIDTH-1:0]             q,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic [LOG2_FIFOS-1:0]        out_fifo
);

   if (QUANTUM < 1) begin : g_bad_quantum
      $error("QUANTUM must be at least 1");
   end

   typedef struct packed {
      logic [LOG2_FIFOS-1:0] fifo;
      logic [WIDTH-1:0]      data;
   } skid_entry_t;

   logic [FIFOS-1:0]      elig;
   logic [LOG2_FIFOS-1:0] rr_ptr;
   logic                  arb_valid;
   logic [LOG2_FIFOS-1:0] arb_idx;
   logic [LOG2_FIFOS-1:0] grant;
   logic                  hs;
   logic [2:0]            free;
   logic                  inflight;
   logic [LOG2_FIFOS-1:0] pop_fifo_d;
   skid_entry_t           skid_mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   skid_occ_e             occ;

   // A FIFO competes only when enabled and holding at least one entry.
   always_comb begin
      elig = '0;
      for (int i = 0; i < FIFOS; i++) begin
         elig[i] = en_mask[i] && (`LLFIFO_CNT_FIELD(count, i, LOG2_DEPTH) != '0);
      end
   end

   rr_arbiter #(
      .N (FIFOS),
      .W (LOG2_FIFOS)
   ) u_arb (
      .req       (elig),
      .ptr       (rr_ptr),
      .gnt_valid (arb_valid),
      .gnt_idx   (arb_idx)
   );

`ifdef LLFIFO_SCHED_WRR_EN
   localparam int BW = log2(QUANTUM);
   logic [BW-1:0]         burst_cnt;
   logic [LOG2_FIFOS-1:0] cur_fifo;
   logic                  keep;

   assign keep  = (burst_cnt != '0) && (burst_cnt < BW'(QUANTUM)) && elig[cur_fifo];
   assign grant = keep ? cur_fifo : arb_idx;

   // Burst tracking: repeat grants extend the burst, any switch restarts it at one.
   always_ff @(posedge clk) begin
      if (rst) begin
         burst_cnt <= '0;
         cur_fifo  <= '0;
      end else if (pop) begin
         burst_cnt <= keep ? burst_cnt + BW'(1) : BW'(1);
         cur_fifo  <= grant;
      end else begin
         burst_cnt <= burst_cnt;
         cur_fifo  <= cur_fifo;
      end
   end
`else
   assign grant = arb_idx;
`endif

   // Slots left once in-flight and stored entries are counted; a same-cycle
   // handshake frees one, which keeps a steady one pop per cycle.
   assign hs   = out_valid && out_ready;
   assign free = 3'd2 + {2'b00, hs} - {1'b0, occ} - {2'b00, inflight};

   // Pop issue toward the buffer; suppressed during reset.
   always_comb begin
      pop      = 1'b0;
      pop_fifo = '0;
      if (!rst && arb_valid && (free != 3'd0)) begin
         pop      = 1'b1;
         pop_fifo = grant;
      end else begin
         pop      = 1'b0;
         pop_fifo = '0;
      end
   end

   // Round-robin pointer moves just past the granted FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (pop) begin
         rr_ptr <= (grant == LOG2_FIFOS'(FIFOS - 1)) ? '0 : grant + LOG2_FIFOS'(1);
      end else begin
         rr_ptr <= rr_ptr;
      end
   end

   // Read-latency capture and 2-entry skid FIFO of {fifo, data}.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight    <= 1'b0;
         pop_fifo_d  <= '0;
         skid_mem[0] <= '0;
         skid_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         occ         <= OCC_EMPTY;
      end else begin
         inflight   <= pop;
         pop_fifo_d <= pop_fifo;
         if (inflight) begin
            skid_mem[wr_ptr] <= '{fifo: pop_fifo_d, data: q};
            wr_ptr           <= ~wr_ptr;
         end else begin
            wr_ptr <= wr_ptr;
         end
         rd_ptr <= hs ? ~rd_ptr : rd_ptr;
         case ({inflight, hs})
            2'b10:   occ <= skid_occ_e'(occ + 2'd1);
            2'b01:   occ <= skid_occ_e'(occ - 2'd1);
            default: occ <= occ;
         endcase
      end
   end

   assign out_valid = (occ != OCC_EMPTY);
   assign out_data  = skid_mem[rd_ptr].data;
   assign out_fifo  = skid_mem[rd_ptr].fifo;

endmodule

// File: tb/tb_llfifo_pop_scheduler.sv
// Self-checking bench: models the buffer as per-FIFO queues and predicts grants,
// credit and output order from the scheduling rules.
module tb_llfifo_pop_scheduler;

   localparam int FIFOS   = 8;
   localparam int LD      = 5;
   localparam int QUANTUM = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  en_mask;
   logic [39:0] count;
   logic        pop;
   logic [2:0]  pop_fifo;
   logic [7:0]  q;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [2:0]  out_fifo;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [2:0] f;
      logic [7:0] d;
      int         age;
   } sb_t;

   sb_t        sb [$];
   logic [7:0] mem [FIFOS][$];
   int         ptr_m   = 0;
   int         cur_m   = 0;
   int         burst_m = 0;

   always #5 clk = ~clk;

   llfifo_pop_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .en_mask   (en_mask),
      .count     (count),
      .pop       (pop),
      .pop_fifo  (pop_fifo),
      .q         (q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_fifo  (out_fifo)
   );

   function automatic logic [7:0] m_elig();
      logic [7:0] e;
      for (int i = 0; i < FIFOS; i++) e[i] = en_mask[i] && (mem[i].size() != 0);
      return e;
   endfunction

   function automatic bit m_valid();
      return (sb.size() != 0) && (sb[0].age >= 1);
   endfunction

   // Room = 2 minus entries popped but not yet delivered, plus a delivery happening now.
   function automatic bit m_pop();
      int room;
      room = 2 - sb.size() + ((m_valid() && out_ready) ? 1 : 0);
      return !rst && (m_elig() != 8'h00) && (room > 0);
   endfunction

   function automatic int m_idx();
      logic [7:0] e;
      e = m_elig();
`ifdef LLFIFO_SCHED_WRR_EN
      if (burst_m > 0 && burst_m < QUANTUM && e[cur_m]) return cur_m;
`endif
      for (int k = 0; k < FIFOS; k++) begin
         if (e[(ptr_m + k) % FIFOS]) return (ptr_m + k) % FIFOS;
      end
      return 0;
   endfunction

   task automatic sync_count();
      for (int i = 0; i < FIFOS; i++) count[i*LD +: LD] = 5'(mem[i].size());
   endtask

   task automatic load(input int f, input int n);
      repeat (n) mem[f].push_back(8'($urandom));
      sync_count();
   endtask

   // Advance one clock acting as the buffer, and update the reference state.
   task automatic tick();
      logic       p;
      logic [2:0] pf;
      logic [7:0] d;
      logic [7:0] e;
      bit         mp, hs, keep;
      int         mi;
      p    = pop;
      pf   = pop_fifo;
      e    = m_elig();
      mp   = m_pop();
      mi   = m_idx();
      hs   = m_valid() && out_ready;
      keep = (burst_m > 0) && (burst_m < QUANTUM) && e[cur_m];
      d    = 8'($urandom);
      @(posedge clk);
      if (rst) begin
         sb.delete();
         ptr_m   = 0;
         cur_m   = 0;
         burst_m = 0;
      end else begin
         if (hs) void'(sb.pop_front());
         foreach (sb[i]) sb[i].age++;
         if (p && mem[pf].size() != 0) begin
            d = mem[pf].pop_front();
            sb.push_back('{f: pf, d: d, age: 0});
         end
         if (mp) begin
            burst_m = (keep && mi == cur_m) ? burst_m + 1 : 1;
            cur_m   = mi;
            ptr_m   = (mi + 1) % FIFOS;
         end
      end
      #1;
      q = d;
      sync_count();
      @(negedge clk);
   endtask

   task automatic do_reset();
      for (int i = 0; i < FIFOS; i++) mem[i].delete();
      sync_count();
      rst = 1'b1;
      en_mask = 8'h00;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0]  exp_p, got_p;
      logic [11:0] exp_o, got_o;
      do_reset();
      en_mask = 8'hff;
      out_ready = 1'b1;
      load(1, 3);
      rst = 1'b1;
      #1;
      n_tests++;
      if (pop !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: pop=%b out_valid=%b want 0 0", pop, out_valid);
      end
      n_tests++;
      if ({pop_fifo, out_fifo, out_data} !== 14'h0) begin
         n_fail++;
         $display("FAIL reset_vals: got %h want 0", {pop_fifo, out_fifo, out_data});
      end
      tick();
      rst = 1'b0;
      #1;
      n_tests++;
      if (pop !== 1'b1 || pop_fifo !== 3'd1) begin
         n_fail++;
         $display("FAIL reset_first_pop: pop=%b fifo=%0d want 1 1", pop, pop_fifo);
      end
      for (int c = 0; c < 7; c++) begin
         if (c != 0) #1;
         exp_p = m_pop() ? {1'b1, 3'(m_idx())} : 4'h0;
         got_p = pop ? {1'b1, pop_fifo} : 4'h0;
         n_tests++;
         if (got_p !== exp_p) begin n_fail++; $display("FAIL reset_pop: got %h want %h", got_p, exp_p); end
         exp_o = m_valid() ? {1'b1, sb[0].f, sb[0].d} : 12'h0;
         got_o = out_valid ? {1'b1, out_fifo, out_data} : 12'h0;
         n_tests++;
         if (got_o !== exp_o) begin n_fail++; $display("FAIL reset_out: got %h want %h", got_o, exp_o); end
         tick();
      end
   endtask

   task automatic test_round_robin();
      logic [3:0]  exp_p, got_p;
      logic [11:0] exp_o, got_o;
      longint      code, want;
      do_reset();
      en_mask = 8'hff;
      out_ready = 1'b1;
      load(0, 2);
      load(3, 2);
      load(5, 2);
      code = 0;
`ifdef LLFIFO_SCHED_WRR_EN
      want = 114466;
`else
      want = 146146;
`endif
      for (int c = 0; c < 10; c++) begin
         #1;
         exp_p = m_pop() ? {1'b1, 3'(m_idx())} : 4'h0;
         got_p = pop ? {1'b1, pop_fifo} : 4'h0;
         n_tests++;
         if (got_p !== exp_p) begin n_fail++; $display("FAIL rr_pop: got %h want %h", got_p, exp_p); end
         exp_o = m_valid() ? {1'b1, sb[0].f, sb[0].d} : 12'h0;
         got_o = out_valid ? {1'b1, out_fifo, out_data} : 12'h0;
         n_tests++;
         if (got_o !== exp_o) begin n_fail++; $display("FAIL rr_out: got %h want %h", got_o, exp_o); end
         if (pop) code = code * 10 + longint'(pop_fifo) + 1;
         tick();
      end
      n_tests++;
      if (code != want) begin n_fail++; $display("FAIL rr_seq: got %0d want %0d", code, want); end
   endtask

   task automatic test_backpressure();
      logic [3:0]  exp_p, got_p;
      logic [11:0] exp_o, got_o;
      int          npops, delivered;
      bit          have;
      logic [7:0]  hold;
      do_reset();
      en_mask = 8'hff;
      out_ready = 1'b0;
      load(4, 4);
      npops = 0;
      delivered = 0;
      have = 1'b0;
      hold = 8'h00;
      for (int c = 0; c < 16; c++) begin
         if (c == 6) out_ready = 1'b1;
         #1;
         exp_p = m_pop() ? {1'b1, 3'(m_idx())} : 4'h0;
         got_p = pop ? {1'b1, pop_fifo} : 4'h0;
         n_tests++;
         if (got_p !== exp_p) begin n_fail++; $display("FAIL bp_pop: got %h want %h", got_p, exp_p); end
         exp_o = m_valid() ? {1'b1, sb[0].f, sb[0].d} : 12'h0;
         got_o = out_valid ? {1'b1, out_fifo, out_data} : 12'h0;
         n_tests++;
         if (got_o !== exp_o) begin n_fail++; $display("FAIL bp_out: got %h want %h", got_o, exp_o); end
         if (c < 6 && pop) npops++;
         if (c < 6 && out_valid && !have) begin
            have = 1'b1;
            hold = out_data;
         end else if (c < 6 && out_valid) begin
            n_tests++;
            if (out_data !== hold) begin n_fail++; $display("FAIL bp_hold: got %h want %h", out_data, hold); end
         end
         if (out_valid && out_ready) delivered++;
         tick();
      end
      n_tests++;
      if (npops != 2) begin n_fail++; $display("FAIL bp_pops: got %0d want 2", npops); end
      n_tests++;
      if (delivered != 4) begin n_fail++; $display("FAIL bp_delivered: got %0d want 4", delivered); end
   endtask

   task automatic test_wrap_mask();
      logic [3:0]  exp_p, got_p;
      logic [11:0] exp_o, got_o;
      longint      code, want;
      int          n_zero, n_other, want_zero;
      do_reset();
      en_mask = 8'hff;
      out_ready = 1'b1;
      load(6, 1);
      code = 0;
      n_zero = 0;
      n_other = 0;
`ifdef LLFIFO_SCHED_WRR_EN
      want = 8888;
      want_zero = 4;
`else
      want = 8181;
      want_zero = 2;
`endif
      for (int c = 0; c < 16; c++) begin
         if (c == 4) begin
            en_mask = 8'h81;
            load(0, 4);
            load(7, 4);
         end
         if (c == 8) en_mask = 8'h01;
         #1;
         exp_p = m_pop() ? {1'b1, 3'(m_idx())} : 4'h0;
         got_p = pop ? {1'b1, pop_fifo} : 4'h0;
         n_tests++;
         if (got_p !== exp_p) begin n_fail++; $display("FAIL wrap_pop: got %h want %h", got_p, exp_p); end
         exp_o = m_valid() ? {1'b1, sb[0].f, sb[0].d} : 12'h0;
         got_o = out_valid ? {1'b1, out_fifo, out_data} : 12'h0;
         n_tests++;
         if (got_o !== exp_o) begin n_fail++; $display("FAIL wrap_out: got %h want %h", got_o, exp_o); end
         if (c >= 4 && c < 8 && pop) code = code * 10 + longint'(pop_fifo) + 1;
         if (c >= 8 && pop && pop_fifo == 3'd0) n_zero++;
         if (c >= 8 && pop && pop_fifo != 3'd0) n_other++;
         tick();
      end
      n_tests++;
      if (code != want) begin n_fail++; $display("FAIL wrap_seq: got %0d want %0d", code, want); end
      n_tests++;
      if (n_other != 0 || n_zero != want_zero) begin
         n_fail++;
         $display("FAIL mask_only0: zero=%0d other=%0d want %0d 0", n_zero, n_other, want_zero);
      end
   endtask

   task automatic test_drain();
      logic [3:0]  exp_p, got_p;
      logic [11:0] exp_o, got_o;
      do_reset();
      en_mask = 8'hff;
      out_ready = 1'b1;
      load(2, 1);
      #1;
      n_tests++;
      if (pop !== 1'b1 || pop_fifo !== 3'd2) begin
         n_fail++;
         $display("FAIL drain_pop: pop=%b fifo=%0d want 1 2", pop, pop_fifo);
      end
      tick();
      #1;
      n_tests++;
      if (pop !== 1'b0) begin n_fail++; $display("FAIL drain_nopop: got %b want 0", pop); end
      for (int c = 0; c < 4; c++) begin
         if (c != 0) #1;
         exp_p = m_pop() ? {1'b1, 3'(m_idx())} : 4'h0;
         got_p = pop ? {1'b1, pop_fifo} : 4'h0;
         n_tests++;
         if (got_p !== exp_p) begin n_fail++; $display("FAIL drain_pop2: got %h want %h", got_p, exp_p); end
         exp_o = m_valid() ? {1'b1, sb[0].f, sb[0].d} : 12'h0;
         got_o = out_valid ? {1'b1, out_fifo, out_data} : 12'h0;
         n_tests++;
         if (got_o !== exp_o) begin n_fail++; $display("FAIL drain_out: got %h want %h", got_o, exp_o); end
         tick();
      end
   endtask

`ifdef LLFIFO_SCHED_WRR_EN
   task automatic test_wrr();
      logic [3:0] exp_p, got_p;
      longint     code;
      int         npops;
      do_reset();
      en_mask = 8'hff;
      out_ready = 1'b1;
      load(1, 6);
      load(2, 6);
      code = 0;
      npops = 0;
      for (int c = 0; c < 16; c++) begin
         #1;
         exp_p = m_pop() ? {1'b1, 3'(m_idx())} : 4'h0;
         got_p = pop ? {1'b1, pop_fifo} : 4'h0;
         n_tests++;
         if (got_p !== exp_p) begin n_fail++; $display("FAIL wrr_pop: got %h want %h", got_p, exp_p); end
         if (pop && npops < 10) begin
            code = code * 10 + longint'(pop_fifo) + 1;
            npops++;
         end
         tick();
      end
      n_tests++;
      if (code != 64'd2222333322) begin n_fail++; $display("FAIL wrr_seq: got %0d want 2222333322", code); end
   endtask
`endif

   task automatic test_random();
      logic [3:0]  exp_p, got_p;
      logic [11:0] exp_o, got_o;
      int          f;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         en_mask   = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 2) == 0) begin
            f = $urandom_range(0, FIFOS - 1);
            if (mem[f].size() < 25) load(f, $urandom_range(1, 3));
         end
         #1;
         exp_p = m_pop() ? {1'b1, 3'(m_idx())} : 4'h0;
         got_p = pop ? {1'b1, pop_fifo} : 4'h0;
         n_tests++;
         if (got_p !== exp_p) begin n_fail++; $display("FAIL rand_pop: cyc %0d got %h want %h", c, got_p, exp_p); end
         exp_o = m_valid() ? {1'b1, sb[0].f, sb[0].d} : 12'h0;
         got_o = out_valid ? {1'b1, out_fifo, out_data} : 12'h0;
         n_tests++;
         if (got_o !== exp_o) begin n_fail++; $display("FAIL rand_out: cyc %0d got %h want %h", c, got_o, exp_o); end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      en_mask = 8'h00;
      out_ready = 1'b0;
      q = 8'h00;
      sync_count();
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_backpressure();
      test_wrap_mask();
      test_drain();
`ifdef LLFIFO_SCHED_WRR_EN
      test_wrr();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
